// File: rtl/i2c_frame_scheduler.sv
// i2c_frame_scheduler
// Sweeps N_CH target boards and pushes each changed command frame to an
// external I2C master as a series of fixed-size register writes. Each write
// carries one register byte (chunk index + 1) followed by CHUNK_BYTES payload
// bytes. Failed chunks are retried, and a channel that keeps failing is flagged
// and dropped for the rest of the sweep. A channel's "last written" copy only
// advances once every chunk of that channel has been acknowledged.
module i2c_frame_scheduler #(
    parameter int N_CH        = 4,
    parameter int FRAME_W     = 88,
    parameter int CHUNK_BYTES = 3,
    parameter int GAP_CYCLES  = 5000,
    parameter int MAX_RETRY   = 2
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    input  logic                         force_i,
    input  logic [7*N_CH-1:0]            dev_id_i,
    input  logic [FRAME_W*N_CH-1:0]      frame_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [N_CH-1:0]              err_flags_o,
    output logic                         i2c_ena_o,
    output logic [6:0]                   i2c_addr_o,
    output logic                         i2c_rw_o,
    output logic [8*(CHUNK_BYTES+1)-1:0] i2c_data_wr_o,
    output logic [7:0]                   i2c_nbytes_o,
    input  logic                         i2c_busy_i,
    input  logic [7:0]                   i2c_byte_counter_i,
    input  logic                         i2c_ack_error_i
);

    localparam int CW    = 8 * CHUNK_BYTES;
    localparam int K     = (FRAME_W + CW - 1) / CW;
    localparam int PAD_W = K * CW;
    localparam int DW    = 8 * (CHUNK_BYTES + 1);
    localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CHW-1:0] LAST_CH    = CHW'(N_CH - 1);
    localparam logic [KW-1:0]  LAST_CHUNK = KW'(K - 1);
    localparam logic [RW-1:0]  RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [GW-1:0]  GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [7:0]     NBYTES     = 8'(CHUNK_BYTES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_LOAD  = 3'd2,
        ST_XFER  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CHW-1:0]     ch_q, ch_d;
    logic [KW-1:0]      chunk_q, chunk_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic               gap_to_check_q, gap_to_check_d;
    logic               force_q, force_d;
    logic               sticky_q, sticky_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [N_CH-1:0]    err_flags_q, err_flags_d;
    logic [FRAME_W-1:0] snap_frame_q, snap_frame_d;
    logic [6:0]         snap_addr_q, snap_addr_d;
    logic               ena_q, ena_d;
    logic [6:0]         addr_q, addr_d;
    logic [DW-1:0]      data_q, data_d;
    logic [7:0]         nbytes_q, nbytes_d;
    logic [FRAME_W-1:0] prev_q [N_CH];
    logic               prev_upd_s;

    logic [FRAME_W-1:0] cur_frame_s;
    logic [FRAME_W-1:0] cur_prev_s;
    logic [6:0]         cur_addr_s;
    logic [PAD_W-1:0]   pad_frame_s;
    logic [DW-1:0]      chunk_word_s;

    // Select the current channel's live inputs and build the outgoing chunk word from the snapshot.
    always_comb begin
        cur_frame_s  = frame_i[int'(ch_q)*FRAME_W +: FRAME_W];
        cur_addr_s   = dev_id_i[int'(ch_q)*7 +: 7];
        cur_prev_s   = prev_q[ch_q];
        pad_frame_s  = PAD_W'(snap_frame_q);
        chunk_word_s = {8'(chunk_q) + 8'd1, pad_frame_s[int'(chunk_q)*CW +: CW]};
    end

    // Sweep sequencing: next state, counters, working registers and the master request.
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        chunk_d        = chunk_q;
        retry_d        = retry_q;
        gap_cnt_d      = gap_cnt_q;
        gap_to_check_d = gap_to_check_q;
        force_d        = force_q;
        sticky_d       = sticky_q;
        err_flags_d    = err_flags_q;
        snap_frame_d   = snap_frame_q;
        snap_addr_d    = snap_addr_q;
        ena_d          = ena_q;
        addr_d         = addr_q;
        data_d         = data_q;
        nbytes_d       = nbytes_q;
        prev_upd_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    force_d     = force_i;
                    err_flags_d = '0;
                    ch_d        = '0;
                    state_d     = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (force_q || (cur_frame_s != cur_prev_s)) begin
                    snap_frame_d = cur_frame_s;
                    snap_addr_d  = cur_addr_s;
                    chunk_d      = '0;
                    retry_d      = '0;
                    state_d      = ST_LOAD;
                end else if (ch_q == LAST_CH) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d = ch_q + CHW'(1);
                end
            end
            ST_LOAD: begin
                // The request registers update together with ena, so the
                // master sees address and data valid in the first XFER cycle.
                addr_d   = snap_addr_q;
                data_d   = chunk_word_s;
                nbytes_d = NBYTES;
                ena_d    = 1'b1;
                sticky_d = 1'b0;
                state_d  = ST_XFER;
            end
            ST_XFER: begin
                if (i2c_ack_error_i) begin
                    sticky_d = 1'b1;
                end else begin
                    sticky_d = sticky_q;
                end
                if (i2c_byte_counter_i >= nbytes_q) begin
                    ena_d   = 1'b0;
                    state_d = ST_WAIT;
                end else begin
                    ena_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!i2c_busy_i && !ena_q) begin
                    gap_cnt_d = '0;
                    if (!sticky_q && (chunk_q != LAST_CHUNK)) begin
                        chunk_d        = chunk_q + KW'(1);
                        retry_d        = '0;
                        gap_to_check_d = 1'b0;
                        state_d        = ST_GAP;
                    end else if (sticky_q && (retry_q < RETRY_MAX)) begin
                        retry_d        = retry_q + RW'(1);
                        gap_to_check_d = 1'b0;
                        state_d        = ST_GAP;
                    end else begin
                        // Channel finished: either fully written or abandoned.
                        if (sticky_q) begin
                            err_flags_d[ch_q] = 1'b1;
                        end else begin
                            prev_upd_s = 1'b1;
                        end
                        if (ch_q == LAST_CH) begin
                            state_d = ST_DONE;
                        end else begin
                            ch_d           = ch_q + CHW'(1);
                            gap_to_check_d = 1'b1;
                            state_d        = ST_GAP;
                        end
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = gap_to_check_q ? ST_CHECK : ST_LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ena_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, counters and registered outputs; reset drops any in-flight request at once.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            chunk_q        <= '0;
            retry_q        <= '0;
            gap_cnt_q      <= '0;
            gap_to_check_q <= 1'b0;
            force_q        <= 1'b0;
            sticky_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_flags_q    <= '0;
            snap_frame_q   <= '0;
            snap_addr_q    <= '0;
            ena_q          <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            nbytes_q       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                prev_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            chunk_q        <= chunk_d;
            retry_q        <= retry_d;
            gap_cnt_q      <= gap_cnt_d;
            gap_to_check_q <= gap_to_check_d;
            force_q        <= force_d;
            sticky_q       <= sticky_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_flags_q    <= err_flags_d;
            snap_frame_q   <= snap_frame_d;
            snap_addr_q    <= snap_addr_d;
            ena_q          <= ena_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            nbytes_q       <= nbytes_d;
            if (prev_upd_s) begin
                prev_q[ch_q] <= snap_frame_q;
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_flags_o   = err_flags_q;
    assign i2c_ena_o     = ena_q;
    assign i2c_addr_o    = addr_q;
    assign i2c_rw_o      = 1'b0;
    assign i2c_data_wr_o = data_q;
    assign i2c_nbytes_o  = nbytes_q;

endmodule

// File: doc/i2c_frame_scheduler.md
I2C_FRAME_SCHEDULER -- requirements
Module: i2c_frame_scheduler

Interface
REQ-001 SHALL expose parameters:
- N_CH, 4, number of I2C target boards
- FRAME_W, 88, command frame width in bits per board
- CHUNK_BYTES, 3, payload bytes per I2C write, after one register byte
- GAP_CYCLES, 5000, idle clocks between successive writes
- MAX_RETRY, 2, retries per chunk after ack error

REQ-002 SHALL expose ports, clock and reset first:
- clock  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request one sweep over all channels
- force  in  1  sampled with start; write every channel regardless of change
- dev_id  in  7*N_CH  7-bit I2C address of channel i at [7i+6:7i]
- frame  in  FRAME_W*N_CH  command frame of channel i at [FRAME_W*i +: FRAME_W]
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- err_flags  out  N_CH  channel i aborted in last sweep
- i2c_ena  out  1  transaction enable to i2c master
- i2c_addr  out  7  target address
- i2c_rw  out  1  always 0 (write)
- i2c_data_wr  out  8*(CHUNK_BYTES+1)  register byte in MSBs, then payload
- i2c_nbytes  out  8  bytes in transaction, = CHUNK_BYTES+1
- i2c_busy  in  1  master busy
- i2c_byte_counter  in  8  bytes completed in current transaction
- i2c_ack_error  in  1  master ack error

Function
REQ-003 SHALL compute K = ceil(FRAME_W / (8*CHUNK_BYTES)) chunks per frame (default 4); chunk k carries frame bits [8*CHUNK_BYTES*k +: 8*CHUNK_BYTES], zero-padded above FRAME_W; register byte = k+1.
REQ-004 SHALL implement states IDLE, CHECK, LOAD, XFER, WAIT, GAP, DONE.
REQ-005 IDLE: start=1 SHALL latch force, clear err_flags, set busy=1, set channel index 0 and go to CHECK; start while busy=1 SHALL be ignored.
REQ-006 CHECK: if force latched or frame[ch] != prev[ch], SHALL snapshot frame[ch] and dev_id[ch] into working registers, set chunk=0, retry=0, go to LOAD; otherwise SHALL advance ch, or go to DONE after ch = N_CH-1.
REQ-007 Mid-sweep changes on frame/dev_id SHALL NOT affect an in-flight channel (snapshot only).
REQ-008 LOAD: SHALL drive i2c_addr, i2c_data_wr and i2c_nbytes, assert i2c_ena=1, clear the sticky error bit, go to XFER.
REQ-009 XFER: SHALL deassert i2c_ena in the cycle after i2c_byte_counter >= i2c_nbytes; SHALL set the sticky error bit on any cycle with i2c_ack_error=1; SHALL enter WAIT after deasserting i2c_ena.
REQ-010 WAIT: on i2c_busy=0 with i2c_ena=0, ok (sticky=0) SHALL advance chunk; error with retry < MAX_RETRY SHALL increment retry and repeat the same chunk; error at retry = MAX_RETRY SHALL set err_flags[ch] and abandon the remaining chunks of ch.
REQ-011 GAP SHALL count GAP_CYCLES clocks and then go to LOAD (next or retried chunk) or to CHECK (next channel). GAP SHALL be skipped after the final transaction of a sweep.
REQ-012 prev[ch] SHALL update to the snapshot only when all K chunks of ch succeeded; an aborted channel SHALL be rewritten on the next sweep.
REQ-013 DONE: SHALL pulse done=1 for exactly one cycle, set busy=0 and return to IDLE; a sweep with no changed channels SHALL reach DONE N_CH+1 cycles after start.
REQ-014 i2c_ena SHALL be 0 in every state except LOAD and XFER.

Reset
REQ-015 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, i2c_ena=0, err_flags=0, prev[*]=0, all counters 0, i2c_addr/i2c_data_wr/i2c_nbytes=0, including mid-transaction.

Verification
REQ-016 Defaults, frame0=88'h1, others 0, start -> exactly 4 writes to dev_id0, data_wr 32'h01000001, 32'h02000000, 32'h03000000, 32'h04000000, >=5000 clocks apart, then done pulse, err_flags=0.
REQ-017 Repeat start with unchanged frames -> no i2c_ena assertion, done 5 cycles after start; with force=1 -> 16 writes.
REQ-018 i2c_ack_error on every transaction of ch2 -> 3 attempts of chunk 0 only, err_flags=4'b0100, ch3 still written; next start rewrites ch2.
REQ-019 frame1 changed during ch1 chunk 2 -> remaining chunks use old snapshot; next sweep writes the new value.
REQ-020 reset_n low during XFER -> i2c_ena=0 and busy=0 in the same cycle; after release, start rewrites all nonzero frames.
